// File: rtl/aexm_wbarb.sv
// Register-file write-port arbiter: in-order pipeline writeback versus late load
// returns held in a 2-entry queue, with WAW kill, read-hazard flag and starvation stall.
module aexm_wbarb #(
    parameter int STARVE_LIM = 4
) (
    input  logic        gclk,
    input  logic        grst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_dat,
    output logic        pipe_stall,
    input  logic        lr_valid,
    output logic        lr_ready,
    input  logic [4:0]  lr_rd,
    input  logic [31:0] lr_dat,
    input  logic [4:0]  rd_chk_a,
    input  logic [4:0]  rd_chk_b,
    output logic        hazard,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdat,
    output logic [1:0]  pend_cnt
);

    typedef struct packed {
        logic        valid;
        logic        killed;
        logic [4:0]  rd;
        logic [31:0] dat;
    } lrEntry_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_HEAD
    } grant_e;

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIM);

    lrEntry_t [1:0] pendQ;
    lrEntry_t [1:0] pendQNext;
    lrEntry_t       newEntry;
    logic [2:0]     starveCnt;
    logic [2:0]     starveNext;
    logic           stallNext;
    grant_e         grant;
    logic           headLive;
    logic           headKilled;
    logic           doPop;
    logic           doPush;

    // Slot 0 is always the head; a valid slot 1 implies a valid slot 0.
    assign pend_cnt   = {1'b0, pendQ[0].valid} + {1'b0, pendQ[1].valid};
    assign lr_ready   = ~grst & (pend_cnt != 2'd2);
    assign headLive   = pendQ[0].valid & ~pendQ[0].killed;
    assign headKilled = pendQ[0].valid & pendQ[0].killed;
    assign doPop      = (grant == GNT_HEAD) | headKilled;
    assign doPush     = lr_valid & lr_ready & (lr_rd != 5'd0);

    assign newEntry = '{valid: 1'b1, killed: 1'b0, rd: lr_rd, dat: lr_dat};

    always_comb begin
        grant = GNT_NONE;
        if (pipe_stall && headLive) begin
            grant = GNT_HEAD;
        end else if (pipe_we && (pipe_rd != 5'd0)) begin
            grant = GNT_PIPE;
        end else if (headLive) begin
            grant = GNT_HEAD;
        end
    end

    // NOTE: every variable gets its default first so no path through this block infers a latch.
    always_comb begin
        pendQNext = pendQ;
        if (doPop) begin
            pendQNext[0] = pendQ[1];
            pendQNext[1] = '0;
        end
        if (doPush) begin
            if (pendQNext[0].valid) begin
                pendQNext[1] = newEntry;
            end else begin
                pendQNext[0] = newEntry;
            end
        end
        // Kill runs after the enqueue: a same-edge pipeline write is the younger one.
        if (grant == GNT_PIPE) begin
            for (int i = 0; i < 2; i++) begin
                if (pendQNext[i].valid && (pendQNext[i].rd == pipe_rd)) begin
                    pendQNext[i].killed = 1'b1;
                end
            end
        end
    end

    always_comb begin
        starveNext = starveCnt;
        stallNext  = pipe_stall;
        if (doPop || !headLive) begin
            starveNext = '0;
        end else if (starveCnt != STARVE_MAX) begin
            starveNext = starveCnt + 3'd1;
        end
        if (doPop) begin
            stallNext = 1'b0;
        end else if (starveNext == STARVE_MAX) begin
            stallNext = 1'b1;
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (pendQ[i].valid && !pendQ[i].killed && (pendQ[i].rd != 5'd0) &&
                ((pendQ[i].rd == rd_chk_a) || (pendQ[i].rd == rd_chk_b))) begin
                hazard = 1'b1;
            end
        end
    end

    // NOTE: the queue payload is reset along with the valid bits; it is only two entries and
    // a reset mid-operation must leave nothing that could later be written.
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            pendQ      <= '0;
            starveCnt  <= '0;
            pipe_stall <= 1'b0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdat    <= '0;
        end else begin
            pendQ      <= pendQNext;
            starveCnt  <= starveNext;
            pipe_stall <= stallNext;
            rf_we      <= (grant != GNT_NONE);
            if (grant == GNT_PIPE) begin
                rf_waddr <= pipe_rd;
                rf_wdat  <= pipe_dat;
            end else if (grant == GNT_HEAD) begin
                rf_waddr <= pendQ[0].rd;
                rf_wdat  <= pendQ[0].dat;
            end
        end
    end

endmodule

// File: tb/tb_aexm_wbarb.sv
// Bench for aexm_wbarb: directed scenarios plus random traffic, checked against a
// queue-based reference model through a write scoreboard.
module tb_aexm_wbarb;

    localparam int STARVE_LIM = 4;

    logic        gclk = 1'b0;
    logic        grst;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_dat;
    logic        pipe_stall;
    logic        lr_valid;
    logic        lr_ready;
    logic [4:0]  lr_rd;
    logic [31:0] lr_dat;
    logic [4:0]  rd_chk_a;
    logic [4:0]  rd_chk_b;
    logic        hazard;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdat;
    logic [1:0]  pend_cnt;

    aexm_wbarb #(.STARVE_LIM(STARVE_LIM)) dut (
        .gclk      (gclk),
        .grst      (grst),
        .pipe_we   (pipe_we),
        .pipe_rd   (pipe_rd),
        .pipe_dat  (pipe_dat),
        .pipe_stall(pipe_stall),
        .lr_valid  (lr_valid),
        .lr_ready  (lr_ready),
        .lr_rd     (lr_rd),
        .lr_dat    (lr_dat),
        .rd_chk_a  (rd_chk_a),
        .rd_chk_b  (rd_chk_b),
        .hazard    (hazard),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdat   (rf_wdat),
        .pend_cnt  (pend_cnt)
    );

    always #5 gclk = ~gclk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] dat;
        bit          killed;
    } mEntry_t;

    typedef struct {
        int          edgeNo;
        logic [4:0]  rd;
        logic [31:0] dat;
    } expWr_t;

    mEntry_t mq[$];
    expWr_t  sb[$];
    int      mStarve = 0;
    bit      mStall = 1'b0;
    int      nCompared = 0;
    int      nMismatch = 0;
    int      edgeNo = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mHazard(input logic [4:0] a, input logic [4:0] b);
        foreach (mq[i]) begin
            if (!mq[i].killed && (mq[i].rd == a || mq[i].rd == b)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Applies the arbitration rules for the coming edge to the model and records any write.
    task automatic modelEdge();
        bit headLive;
        bit pipeWins;
        bit headWins;
        bit popped;
        bit wasEmpty;
        bit accept;
        headLive = (mq.size() > 0) && !mq[0].killed;
        pipeWins = 1'b0;
        headWins = 1'b0;
        if (mStall && headLive)              headWins = 1'b1;
        else if (pipe_we && pipe_rd != 5'd0) pipeWins = 1'b1;
        else if (headLive)                   headWins = 1'b1;
        accept = lr_valid && (mq.size() < 2) && (lr_rd != 5'd0);
        if (pipeWins) sb.push_back('{edgeNo + 1, pipe_rd, pipe_dat});
        if (headWins) sb.push_back('{edgeNo + 1, mq[0].rd, mq[0].dat});
        popped   = headWins || ((mq.size() > 0) && mq[0].killed);
        wasEmpty = (mq.size() == 0);
        if (popped) void'(mq.pop_front());
        if (accept) mq.push_back('{lr_rd, lr_dat, 1'b0});
        if (pipeWins) begin
            foreach (mq[i]) if (mq[i].rd == pipe_rd) mq[i].killed = 1'b1;
        end
        if (popped || wasEmpty) mStarve = 0;
        else                    mStarve++;
        if (popped)                        mStall = 1'b0;
        else if (mStarve == STARVE_LIM)    mStall = 1'b1;
    endtask

    // Entered at posedge+2; drives one cycle of inputs, checks status, returns at next posedge+2.
    task automatic step(input logic pw, input logic [4:0] prd, input logic [31:0] pdat,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                        input logic [4:0] ca, input logic [4:0] cb);
        pipe_we  = pw;
        pipe_rd  = prd;
        pipe_dat = pdat;
        lr_valid = lv;
        lr_rd    = lrd;
        lr_dat   = ldat;
        rd_chk_a = ca;
        rd_chk_b = cb;
        #1;
        check("lr_ready",   32'(lr_ready),   32'(mq.size() < 2));
        check("pend_cnt",   32'(pend_cnt),   32'(mq.size()));
        check("pipe_stall", 32'(pipe_stall), 32'(mStall));
        check("hazard",     32'(hazard),     32'(mHazard(ca, cb)));
        modelEdge();
        @(posedge gclk);
        #2;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    endtask

    // Write monitor: pops the scoreboard whenever the DUT presents a write.
    always @(posedge gclk) begin
        expWr_t e;
        edgeNo++;
        #1;
        if (rf_we) begin
            if (sb.size() == 0) begin
                check("wr_unexpected", 32'(rf_we), 32'd0);
            end else begin
                e = sb.pop_front();
                check("wr_edge", edgeNo, e.edgeNo);
                check("wr_addr", 32'(rf_waddr), 32'(e.rd));
                check("wr_data", rf_wdat, e.dat);
            end
        end else if (sb.size() != 0 && sb[0].edgeNo <= edgeNo) begin
            check("wr_missing", 32'(rf_we), 32'd1);
            void'(sb.pop_front());
        end
    end

    initial begin
        logic        hPw;
        logic [4:0]  hPrd;
        logic [31:0] hPdat;

        grst = 1'b1;
        pipe_we = 1'b0; pipe_rd = '0; pipe_dat = '0;
        lr_valid = 1'b0; lr_rd = '0; lr_dat = '0;
        rd_chk_a = '0; rd_chk_b = '0;
        repeat (3) @(posedge gclk);
        #2;
        check("rst_rf_we",    32'(rf_we),      32'd0);
        check("rst_lr_ready", 32'(lr_ready),   32'd0);
        check("rst_pend_cnt", 32'(pend_cnt),   32'd0);
        check("rst_stall",    32'(pipe_stall), 32'd0);
        grst = 1'b0;

        // Late return alone: queued one edge, written the next.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hDEADBEEF, 5'd0, 5'd0);
        check("t1_pend_after_accept", 32'(pend_cnt), 32'd1);
        idle();
        check("t1_rf_we",   32'(rf_we),    32'd1);
        check("t1_waddr",   32'(rf_waddr), 32'd3);
        check("t1_wdat",    rf_wdat,       32'hDEADBEEF);
        check("t1_pend_0",  32'(pend_cnt), 32'd0);

        // Pipeline and late return on the same edge: pipeline first.
        step(1'b1, 5'd5, 32'h11, 1'b1, 5'd7, 32'h77, 5'd0, 5'd0);
        check("t2_first_r5", 32'(rf_waddr), 32'd5);
        idle();
        check("t2_then_r7",  32'(rf_waddr), 32'd7);

        // Starvation: queue r8, r9 while the pipeline keeps r2 busy.
        step(1'b1, 5'd2, 32'h22, 1'b1, 5'd8, 32'h88, 5'd0, 5'd0);
        step(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h99, 5'd0, 5'd0);
        check("t3_full_not_ready", 32'(lr_ready), 32'd0);
        check("t3_pend_2",         32'(pend_cnt), 32'd2);
        step(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        step(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        check("t3_no_stall_yet", 32'(pipe_stall), 32'd0);
        step(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        check("t3_stall_up", 32'(pipe_stall), 32'd1);
        step(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        check("t3_head_r8",   32'(rf_waddr),   32'd8);
        check("t3_head_dat",  rf_wdat,         32'h88);
        check("t3_stall_off", 32'(pipe_stall), 32'd0);
        step(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        check("t3_pipe_r2", 32'(rf_waddr), 32'd2);
        idle();
        check("t3_drain_r9", 32'(rf_waddr), 32'd9);

        // WAW kill: queued r10=0xAA overtaken by pipeline r10=0xBB.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hAA, 5'd10, 5'd0);
        check("t4_hazard_on", 32'(hazard), 32'd1);
        step(1'b1, 5'd10, 32'hBB, 1'b0, 5'd0, 32'd0, 5'd10, 5'd0);
        check("t4_hazard_off", 32'(hazard), 32'd0);
        check("t4_wdat_bb",    rf_wdat,     32'hBB);
        idle();
        check("t4_killed_no_write", 32'(rf_we),    32'd0);
        check("t4_killed_popped",   32'(pend_cnt), 32'd0);

        // r0 requests from both sides.
        step(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 5'd0, 5'd0);
        check("t5_no_write", 32'(rf_we),    32'd0);
        check("t5_no_queue", 32'(pend_cnt), 32'd0);

        // Reset with a full queue and stall raised.
        step(1'b1, 5'd4, 32'h44, 1'b1, 5'd12, 32'hC12, 5'd0, 5'd0);
        step(1'b1, 5'd4, 32'h44, 1'b1, 5'd13, 32'hC13, 5'd0, 5'd0);
        repeat (3) step(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0, 5'd12, 5'd13);
        check("t6_stall_before", 32'(pipe_stall), 32'd1);
        check("t6_pend_before",  32'(pend_cnt),   32'd2);
        grst = 1'b1;
        #1;
        check("t6_rf_we",    32'(rf_we),      32'd0);
        check("t6_waddr",    32'(rf_waddr),   32'd0);
        check("t6_wdat",     rf_wdat,         32'd0);
        check("t6_stall",    32'(pipe_stall), 32'd0);
        check("t6_pend",     32'(pend_cnt),   32'd0);
        check("t6_lr_ready", 32'(lr_ready),   32'd0);
        check("t6_hazard",   32'(hazard),     32'd0);
        mq.delete();
        sb.delete();
        mStarve = 0;
        mStall  = 1'b0;
        pipe_we = 1'b0;
        lr_valid = 1'b0;
        @(posedge gclk);
        @(posedge gclk);
        #2;
        grst = 1'b0;
        repeat (3) idle();

        // Random traffic over a small register range so kills and hazards are frequent.
        hPw = 1'b0; hPrd = '0; hPdat = '0;
        for (int n = 0; n < 2000; n++) begin
            if (!mStall) begin
                hPw   = ($urandom_range(0, 9) < 6);
                hPrd  = 5'($urandom_range(0, 7));
                hPdat = $urandom();
            end
            step(hPw, hPrd, hPdat,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        repeat (4) idle();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/aexm_wbarb.md
Name: aexm_wbarb

Overview:
- Write-port arbiter for the general-purpose register file: one write port (address, data, enable) shared by two requesters.
- Requester 1 is in-order pipeline writeback (ALU result, link, aligned load).
- Requester 2 is late load returns from the MCU/IO path, which arrive asynchronously to pipeline flow.
- Late returns are buffered in a 2-entry queue. The block flags read hazards on pending registers and forces a pipeline stall when queued data starves.

Parameters:
STARVE_LIM, 4, cycles a valid queued head may be denied the port before pipe_stall asserts (1..7)

Ports:
gclk  in  1  clock; all state on rising edge
grst  in  1  reset, asynchronous, active-high
pipe_we  in  1  pipeline writeback request this cycle
pipe_rd  in  5  pipeline destination register
pipe_dat  in  32  pipeline write data
pipe_stall  out  1  registered; upstream must hold pipe_we/pipe_rd/pipe_dat stable while high
lr_valid  in  1  late return offered
lr_ready  out  1  queue can accept (combinational from registered count)
lr_rd  in  5  late return destination register
lr_dat  in  32  late return data
rd_chk_a  in  5  register-file read address A, for hazard check
rd_chk_b  in  5  register-file read address B, for hazard check
hazard  out  1  combinational; rd_chk_a or rd_chk_b matches a live queued entry
rf_we  out  1  registered register-file write enable
rf_waddr  out  5  registered write address
rf_wdat  out  32  registered write data
pend_cnt  out  2  number of queue entries (0..2)

Behaviour:
- Reset (async, grst high):
  - rf_we=0, rf_waddr=0, rf_wdat=0, pipe_stall=0, pend_cnt=0.
  - All queue entries invalid; starvation counter=0.
  - lr_ready=0 while grst high; lr_ready=1 from the first cycle after release.
  - Reset mid-operation discards queued entries without writing them.
- Acceptance:
  - Late return accepted on an edge where lr_valid && lr_ready; lr_ready = (pend_cnt<2).
  - lr_rd==0 is accepted and discarded, not enqueued.
- Queue:
  - 2-entry FIFO; each entry holds valid, killed, rd, dat.
  - Simultaneous enqueue and pop at count=2 is not possible, since lr_ready=0.
  - Enqueue and pop on the same edge at count=1 leaves count=1.
- Grant (evaluated each edge; result appears on rf_* after that edge, 1-cycle latency):
  1. If pipe_stall=1 and the head is live (valid, not killed): write the head, pop it. pipe_we is not consumed that edge.
  2. Else if pipe_we && pipe_rd!=0: write the pipeline request.
  3. Else if the head is live: write the head, pop it.
  4. Else rf_we=0.
  - pipe_we with pipe_rd==0 is consumed with no write. The r0 write is suppressed.
  - A killed head is popped with no write, on any edge, concurrently with a pipeline grant.
- Latency:
  - Pipeline: request sampled at edge E appears on rf_* after edge E.
  - Late return: data accepted at edge E is written no earlier than after edge E+1. There is no bypass.
- WAW kill:
  - A pipeline write consumed at edge E marks killed every valid entry with the same rd.
  - This includes an entry enqueued on the same edge E; the pipeline write is treated as younger.
- Starvation:
  - The counter increments on each edge where the head is live and not granted.
  - The counter clears on any pop, on reset, or when the queue is empty.
  - pipe_stall is set on the edge where the counter reaches STARVE_LIM.
  - pipe_stall clears on the edge the head pops.
- Hazard: hazard=1 iff a valid, non-killed entry has rd==rd_chk_a or rd==rd_chk_b, with rd!=0.

Test Plan:
- Reset release, lr_valid=1 lr_rd=3 lr_dat=0xDEADBEEF, pipe_we=0 -> lr_ready=1; pend_cnt=1 after accept edge; rf_we=1 rf_waddr=3 rf_wdat=0xDEADBEEF one cycle later; pend_cnt back to 0.
- pipe_we=1 rd=5 dat=0x11 on the same edge as a late return for rd=7 with queue empty -> rf_we for r5 first; r7 written the following cycle if pipe_we=0.
- Fill the queue (rd=8, rd=9) while pipe_we is held high to rd=2 -> lr_ready=0 at pend_cnt=2; pipe_stall rises after 4 denied edges; next edge writes r8, stall drops; pipeline request then granted.
- Queue holds rd=10 dat=0xAA; pipeline writes rd=10 dat=0xBB -> entry killed, hazard on rd_chk_a=10 drops; r10 final write is 0xBB; 0xAA never written.
- pipe_we=1 rd=0, and lr rd=0 -> no rf_we assertion; pend_cnt stays 0.
- Assert grst mid-cycle with pend_cnt=2 and pipe_stall=1 -> all outputs 0 immediately; no write of queued data after release.
